result_deskew_collector: RTL and testbench

Downstream stage of the 4x4 systolic array and its feature/weight loader. It captures the diagonally skewed activation outputs of the array's bottom row, reassembles them into a row-major N×N result tile, and streams the tile out one element per handshake. This replaces ad-hoc per-cycle result writes into feature memory with a single valid/ready output stream for the writeback path.

---
 rtl/tpu_pkg.sv | 26 ++
 rtl/result_buffer.sv | 44 ++++
 rtl/result_deskew_collector.sv | 160 ++++++++++++++++
 tb/tb_result_deskew_collector.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// tpu_pkg: shared definitions for the systolic array's result path.
//   DATA_W_DEF / N_DEF : default element width and array dimension
//   WAVES              : wavefronts per tile (2N-1) for the default N
//   TILE               : elements per tile (N*N) for the default N
//   state_t            : result collector FSM states
//   transpose_index    : maps a column-major drain position to a row-major buffer slot
package tpu_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int N_DEF      = 4;
    localparam int WAVES      = 2 * N_DEF - 1;
    localparam int TILE       = N_DEF * N_DEF;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        CAPTURE,
        DRAIN
    } state_t;

    // Drain position k of an n x n tile read out column-major.
    function automatic int transpose_index(input int k, input int n);
        return (k % n) * n + k / n;
    endfunction

endpackage

// File: rtl/result_buffer.sv
// result_buffer: DEPTH x DATA_W register file holding one result tile.
//   clk, rst : clock; rst clears only the read register, not the storage
//   wr_en    : N independent write strobes, one per array column
//   wr_addr  : N packed write addresses, port c at [c*AW +: AW]
//   wr_data  : N packed write data words, port c at [c*DATA_W +: DATA_W]
//   rd_en    : load rd_data from rd_addr on this edge
//   rd_addr  : read address
//   rd_data  : registered read data (holds while rd_en is low)
// Write addresses within one cycle are always distinct (one per tile row/column pair).
module result_buffer #(
    parameter int DATA_W = 8,
    parameter int N      = 4,
    parameter int DEPTH  = N * N,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N-1:0]          wr_en,
    input  logic [N*AW-1:0]       wr_addr,
    input  logic [N*DATA_W-1:0]   wr_data,
    input  logic                  rd_en,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_W-1:0]     rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int c = 0; c < N; c++) begin
            if (wr_en[c]) begin
                mem[wr_addr[c*AW +: AW]] <= wr_data[c*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/result_deskew_collector.sv
// result_deskew_collector: captures the diagonally skewed bottom-row outputs of
// the N x N systolic array, rebuilds the N x N tile and streams it out one
// element per valid/ready handshake.
//   clk, rst  : clock, synchronous active-high reset
//   start     : arms capture (accepted only in IDLE and not while done pulses)
//   in_valid  : res_in carries one wavefront
//   res_in    : column c at [c*DATA_W +: DATA_W]
//   out_data  : current tile element (registered)
//   out_valid : out_data valid
//   out_ready : consumer accepts out_data
//   out_last  : final element of the tile
//   busy      : high in ARMED, CAPTURE and DRAIN
//   done      : one-cycle pulse after the final handshake
// Build option: define RESULT_DESKEW_TRANSPOSE_EN to drain the tile column-major
// instead of row-major.
module result_deskew_collector
    import tpu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int N      = N_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                in_valid,
    input  logic [N*DATA_W-1:0] res_in,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_last,
    output logic                busy,
    output logic                done
);

    localparam int N_TILE  = N * N;
    localparam int N_WAVES = 2 * N - 1;
    localparam int AW      = (N_TILE > 1) ? $clog2(N_TILE) : 1;
    localparam int TW      = (N_WAVES > 1) ? $clog2(N_WAVES) : 1;

    state_t          state;
    logic [TW-1:0]   t;
    logic [AW-1:0]   k;

    logic            capture_fire;
    logic            last_wave;
    logic            drain_fire;
    logic            last_elem;
    logic [N-1:0]    wr_en;
    logic [N*AW-1:0] wr_addr;
    logic            rd_en;
    logic [AW-1:0]   rd_addr;

    // Buffer slot that holds drain position kk.
    function automatic logic [AW-1:0] drain_addr(input int kk);
`ifdef RESULT_DESKEW_TRANSPOSE_EN
        return AW'(transpose_index(kk, N));
`else
        return AW'(kk);
`endif
    endfunction

    // t is held at 0 in ARMED, so the same end-of-capture test covers both states.
    assign capture_fire = in_valid && (state == ARMED || state == CAPTURE);
    assign last_wave    = capture_fire && (int'(t) == N_WAVES - 1);
    assign drain_fire   = (state == DRAIN) && out_valid && out_ready;
    assign last_elem    = (int'(k) == N_TILE - 1);

    // Deskew: wave t carries row (t-c) in column c while that row is inside the tile.
    always_comb begin
        wr_en   = '0;
        wr_addr = '0;
        for (int c = 0; c < N; c++) begin
            int row;
            row = int'(t) - c;
            if (capture_fire && row >= 0 && row < N) begin
                wr_en[c]             = 1'b1;
                wr_addr[c*AW +: AW]  = AW'(row * N + c);
            end
        end
    end

    // Prefetch the next element: slot 0 on entry to DRAIN, k+1 on each handshake.
    // Slot 0 is written by wave 0, so it is safe to read on the final capture edge.
    always_comb begin
        rd_en   = last_wave || (drain_fire && !last_elem);
        rd_addr = drain_addr((state == DRAIN) ? int'(k) + 1 : 0);
    end

    result_buffer #(
        .DATA_W (DATA_W),
        .N      (N),
        .DEPTH  (N_TILE),
        .AW     (AW)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (res_in),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (out_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            t         <= '0;
            k         <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // A start coinciding with the done pulse is dropped.
                    if (start && !done) begin
                        state <= ARMED;
                        busy  <= 1'b1;
                        t     <= '0;
                        k     <= '0;
                    end
                end
                ARMED, CAPTURE: begin
                    if (in_valid) begin
                        if (last_wave) begin
                            state     <= DRAIN;
                            t         <= '0;
                            k         <= '0;
                            out_valid <= 1'b1;
                            out_last  <= (N_TILE == 1);
                        end else begin
                            state <= CAPTURE;
                            t     <= t + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_fire) begin
                        if (last_elem) begin
                            state     <= IDLE;
                            k         <= '0;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            k        <= k + 1'b1;
                            out_last <= (int'(k) == N_TILE - 2);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_result_deskew_collector.sv
module tb_result_deskew_collector;

    localparam int DW = 8;
    localparam int NN = 4;
    localparam int TL = NN * NN;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic [NN*DW-1:0]  res_in = '0;
    logic [DW-1:0]     out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              out_last;
    logic              busy;
    logic              done;

    int n_checks = 0;
    int n_errors = 0;

    result_deskew_collector #(.DATA_W(DW), .N(NN)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .res_in    (res_in),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Outputs are registered; sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wavefront t: column c carries element (row t-c, col c) = 16*row+c, else filler EE.
    function automatic logic [NN*DW-1:0] wave(input int t);
        logic [NN*DW-1:0] w;
        w = '0;
        for (int c = 0; c < NN; c++) begin
            int r;
            r = t - c;
            if (r >= 0 && r < NN) w[c*DW +: DW] = DW'(16 * r + c);
            else                  w[c*DW +: DW] = 8'hEE;
        end
        return w;
    endfunction

    // Expected value of the idx-th drained element.
    function automatic logic [31:0] exp_elem(input int idx);
`ifdef RESULT_DESKEW_TRANSPOSE_EN
        return 32'(16 * (idx % NN) + idx / NN);
`else
        return 32'(16 * (idx / NN) + idx % NN);
`endif
    endfunction

    // Start a tile and feed its 7 waves; `gap` idle cycles after wave 2,
    // optional stray start during capture.
    task automatic send_tile(input int gap, input bit glitch);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        for (int t = 0; t < 2 * NN - 1; t++) begin
            in_valid = 1'b1;
            res_in   = wave(t);
            start    = glitch && (t == 4);
            tick();
            start    = 1'b0;
            if (t == 2) begin
                for (int g = 0; g < gap; g++) begin
                    in_valid = 1'b0;
                    res_in   = 32'hDEADBEEF;
                    tick();
                    chk("gap_valid_low", out_valid, 0);
                    chk("gap_busy", busy, 1);
                end
            end
            if (t < 2 * NN - 2) chk("pre_valid_low", out_valid, 0);
        end
        in_valid = 1'b0;
        res_in   = 32'hA5A5A5A5;
        chk("valid_rise", out_valid, 1);
    endtask

    // Drain up to `stop` elements. mode 0: ready always 1, mode 1: ready 1,0,0,1 pattern.
    task automatic drain(input int mode, input int stop, input bit glitch);
        int idx;
        int cyc;
        idx = 0;
        cyc = 0;
        while (idx < stop && cyc < 200) begin
            chk("drain_valid", out_valid, 1);
            chk("drain_busy", busy, 1);
            chk($sformatf("data[%0d]", idx), out_data, exp_elem(idx));
            chk($sformatf("last[%0d]", idx), out_last, (idx == TL - 1));
            out_ready = (mode == 0) ? 1'b1 : ((cyc % 4) == 0 || (cyc % 4) == 3);
            start     = glitch && (idx == 3);
            tick();
            start     = 1'b0;
            if (out_ready) idx++;
            cyc++;
        end
        chk("drain_within_bound", (cyc < 200), 1);
        if (stop == TL) begin
            chk("done_pulse", done, 1);
            chk("done_valid_low", out_valid, 0);
            chk("done_busy_low", busy, 0);
            chk("done_last_low", out_last, 0);
            // start in the done cycle must be dropped
            start = 1'b1;
            tick();
            start = 1'b0;
            chk("done_single", done, 0);
            chk("start_on_done_ignored", busy, 0);
            out_ready = 1'b0;
        end
    endtask

    initial begin
        // Reset values
        rst = 1'b1;
        tick();
        tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_out_data", out_data, 0);
        rst = 1'b0;
        // in_valid in IDLE is ignored
        in_valid = 1'b1;
        res_in   = wave(0);
        tick();
        in_valid = 1'b0;
        chk("idle_invalid_busy", busy, 0);
        chk("idle_invalid_valid", out_valid, 0);

        // Basic tile, ready held high
        send_tile(0, 1'b0);
        drain(0, TL, 1'b0);

        // Backpressure
        send_tile(0, 1'b0);
        drain(1, TL, 1'b0);

        // in_valid gap of 3 cycles between waves 2 and 3
        send_tile(3, 1'b0);
        drain(0, TL, 1'b0);

        // Reset during DRAIN at k=5
        send_tile(0, 1'b0);
        drain(0, 5, 1'b0);
        rst       = 1'b1;
        out_ready = 1'b1;
        tick();
        rst       = 1'b0;
        out_ready = 1'b0;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_last", out_last, 0);
        chk("midrst_done", done, 0);
        chk("midrst_data", out_data, 0);
        send_tile(0, 1'b0);
        drain(0, TL, 1'b0);

        // Stray starts during CAPTURE and DRAIN
        send_tile(0, 1'b1);
        drain(1, TL, 1'b1);
        tick();
        chk("post_idle_busy", busy, 0);
        chk("post_idle_done", done, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
